// File: rtl/ps2_rx_decoder.sv
// ps2_rx_decoder
// Receives 11-bit device-to-host PS/2 frames, validates start/parity/stop,
// folds the F0 (break) and E0 (extended) prefixes into the following byte,
// and presents one decoded key event per oflag pulse.
//
// Ports
//   clk        system clock (only clock in the block)
//   rst        asynchronous reset, active low
//   ps2_clk    PS/2 clock line, asynchronous to clk
//   ps2_data   PS/2 data line, asynchronous to clk
//   keycode    {brk | byte[7], byte[6:0]}, held between events
//   oflag      one-cycle pulse, keycode/extended valid in the same cycle
//   extended   event was preceded by E0, updated with keycode
//   frame_err  one-cycle pulse on start/parity/stop error or timeout
//
// FSM states
//   state  | meaning
//   IDLE   | waiting for a start bit (falling edge with data = 0)
//   RECV   | shifting in data bits 0-7, parity (8) and stop (9)
//   DONE   | one cycle; frame result and decoded event are presented

module ps2_rx_decoder #(
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 200000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] keycode,
   output logic       oflag,
   output logic       extended,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // two-flop synchronisers, idle-high lines reset to 1
   logic [1:0] clk_sync;
   logic [1:0] dat_sync;
   logic       clk_s;
   logic       data_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
      end
   end

   assign clk_s  = clk_sync[1];
   assign data_s = dat_sync[1];

   // clock filter: the filtered level flips only after FILTER_LEN
   // consecutive synchronised samples that disagree with it
   logic [FW-1:0] flt_cnt;
   logic          clk_filt;
   logic          clk_filt_d;
   logic          fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flt_cnt    <= '0;
         clk_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
      end else begin
         clk_filt_d <= clk_filt;
         if (clk_s == clk_filt) begin
            flt_cnt <= '0;
         end else if (flt_cnt == FW'(FILTER_LEN - 1)) begin
            flt_cnt  <= '0;
            clk_filt <= clk_s;
         end else begin
            flt_cnt <= flt_cnt + 1'b1;
         end
      end
   end

   assign fall = clk_filt_d & ~clk_filt;

   // receiver state
   state_t        state,      state_nxt;
   logic [3:0]    bitcnt,     bitcnt_nxt;
   logic [8:0]    shift_reg,  shift_nxt;
   logic [TW-1:0] tmo_cnt,    tmo_nxt;
   logic          brk_pend,   brk_nxt;
   logic          ext_pend,   ext_nxt;
   logic [7:0]    keycode_nxt;
   logic          extended_nxt;
   logic          oflag_nxt;
   logic          ferr_nxt;
   logic [7:0]    rx_byte;
   logic          frame_ok;

   assign rx_byte = shift_reg[7:0];
   // evaluated on the stop-bit edge: shift_reg holds data+parity, data_s is stop
   assign frame_ok = (^shift_reg) & data_s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         bitcnt    <= '0;
         shift_reg <= '0;
         tmo_cnt   <= '0;
         brk_pend  <= 1'b0;
         ext_pend  <= 1'b0;
         keycode   <= 8'h00;
         extended  <= 1'b0;
         oflag     <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         bitcnt    <= bitcnt_nxt;
         shift_reg <= shift_nxt;
         tmo_cnt   <= tmo_nxt;
         brk_pend  <= brk_nxt;
         ext_pend  <= ext_nxt;
         keycode   <= keycode_nxt;
         extended  <= extended_nxt;
         oflag     <= oflag_nxt;
         frame_err <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      bitcnt_nxt   = bitcnt;
      shift_nxt    = shift_reg;
      tmo_nxt      = tmo_cnt;
      brk_nxt      = brk_pend;
      ext_nxt      = ext_pend;
      keycode_nxt  = keycode;
      extended_nxt = extended;
      oflag_nxt    = 1'b0;
      ferr_nxt     = 1'b0;

      case (state)
         S_IDLE: begin
            tmo_nxt = '0;
            if (fall) begin
               if (!data_s) begin
                  state_nxt  = S_RECV;
                  bitcnt_nxt = '0;
               end else begin
                  ferr_nxt = 1'b1;
               end
            end
         end

         S_RECV: begin
            if (fall) begin
               tmo_nxt = '0;
               if (bitcnt == 4'd9) begin
                  // result registered so the pulses land in the DONE cycle
                  state_nxt  = S_DONE;
                  bitcnt_nxt = '0;
                  if (frame_ok) begin
                     if (rx_byte == 8'hF0) begin
                        brk_nxt = 1'b1;
                     end else if (rx_byte == 8'hE0) begin
                        ext_nxt = 1'b1;
                     end else begin
                        keycode_nxt  = {brk_pend | rx_byte[7], rx_byte[6:0]};
                        extended_nxt = ext_pend;
                        oflag_nxt    = 1'b1;
                        brk_nxt      = 1'b0;
                        ext_nxt      = 1'b0;
                     end
                  end else begin
                     ferr_nxt = 1'b1;
                  end
               end else begin
                  shift_nxt  = {data_s, shift_reg[8:1]};
                  bitcnt_nxt = bitcnt + 4'd1;
               end
            end else if (tmo_cnt == TW'(TIMEOUT_CYC)) begin
               state_nxt  = S_IDLE;
               tmo_nxt    = '0;
               bitcnt_nxt = '0;
               ferr_nxt   = 1'b1;
            end else begin
               tmo_nxt = tmo_cnt + 1'b1;
            end
         end

         S_DONE: begin
            // an edge here is impossible at legal PS/2 rates and is ignored
            state_nxt = S_IDLE;
         end

         default: begin
            state_nxt  = S_IDLE;
            bitcnt_nxt = '0;
            tmo_nxt    = '0;
         end
      endcase

      if (ferr_nxt) begin
         brk_nxt = 1'b0;
         ext_nxt = 1'b0;
      end
   end

endmodule
